// File: rtl/beat_judge_ctrl.sv
// beat_judge_ctrl: per-beat sequencer for the 4-lane Finger Dancer button
// capture register. It opens a timed capture window on each beat, collects
// new key presses, judges them against the expected note pattern, clears the
// capture register and keeps a saturating score and combo for the display.
// Optional feature macro: COMBO_BONUS_EN (each hit adds HIT_PTS + combo/8).
`timescale 1ns/1ps

module beat_judge_ctrl #(
    parameter int WIN_CYCLES = 8,
    parameter int HIT_PTS    = 10,
    parameter int SCORE_W    = 16,
    parameter int COMBO_W    = 8
) (
    input  logic               C,
    input  logic               INIT_n,
    input  logic               start,
    input  logic               stop,
    input  logic               beat,
    input  logic [3:0]         note,
    input  logic [3:0]         keys,
    output logic               reg_clr,
    output logic               hit,
    output logic               miss,
    output logic [SCORE_W-1:0] score,
    output logic [COMBO_W-1:0] combo,
    output logic               overrun,
    output logic               busy
);

    localparam int CNT_W = (WIN_CYCLES > 2) ? $clog2(WIN_CYCLES) : 1;
    localparam int SUM_W = ((SCORE_W > COMBO_W) ? SCORE_W : COMBO_W) + 34;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [COMBO_W-1:0] COMBO_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BEAT,
        S_WINDOW,
        S_JUDGE,
        S_CLEAR
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [3:0]         r_acc;
    logic [3:0]         r_keyPrev;
    logic [3:0]         r_noteL;
    logic               r_regClr;
    logic               r_hit;
    logic               r_miss;
    logic [SCORE_W-1:0] r_score;
    logic [COMBO_W-1:0] r_combo;
    logic               r_overrun;
    logic               r_busy;

    logic [3:0]         w_rise;
    logic               w_isHit;
    logic               w_isMiss;
    logic [SUM_W-1:0]   w_addend;
    logic [SUM_W-1:0]   w_sum;
    logic [SCORE_W-1:0] w_scoreSat;
    logic [COMBO_W-1:0] w_comboInc;

    // Judgement arithmetic: new presses, verdict, saturating score and combo.
    always_comb begin
        w_rise   = keys & ~r_keyPrev;
        w_isHit  = (r_noteL != 4'd0) && (r_acc == r_noteL);
        w_isMiss = (r_acc != r_noteL);
`ifdef COMBO_BONUS_EN
        w_addend = SUM_W'(HIT_PTS) + SUM_W'(r_combo >> 3);
`else
        w_addend = SUM_W'(HIT_PTS);
`endif
        w_sum      = SUM_W'(r_score) + w_addend;
        w_scoreSat = (w_sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : w_sum[SCORE_W-1:0];
        w_comboInc = (r_combo == COMBO_MAX) ? r_combo : r_combo + 1'b1;
    end

    // Game sequencer: stop overrides everything, otherwise step the beat cycle.
    always_ff @(posedge C or negedge INIT_n) begin
        if (!INIT_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_acc     <= 4'd0;
            r_keyPrev <= 4'd0;
            r_noteL   <= 4'd0;
            r_regClr  <= 1'b1;
            r_hit     <= 1'b0;
            r_miss    <= 1'b0;
            r_score   <= '0;
            r_combo   <= '0;
            r_overrun <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_keyPrev <= keys;
            r_hit     <= 1'b0;
            r_miss    <= 1'b0;
            if (stop) begin
                r_state  <= S_IDLE;
                r_regClr <= 1'b1;
                r_busy   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_score   <= '0;
                            r_combo   <= '0;
                            r_overrun <= 1'b0;
                            r_state   <= S_WAIT_BEAT;
                            r_regClr  <= 1'b0;
                            r_busy    <= 1'b1;
                        end
                    end
                    S_WAIT_BEAT: begin
                        if (beat) begin
                            r_noteL <= note;
                            r_cnt   <= CNT_W'(WIN_CYCLES - 1);
                            r_acc   <= 4'd0;
                            r_state <= S_WINDOW;
                        end
                    end
                    S_WINDOW: begin
                        r_acc <= r_acc | w_rise;
                        if (beat) begin
                            r_overrun <= 1'b1;
                        end
                        if (r_cnt == '0) begin
                            r_state <= S_JUDGE;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    S_JUDGE: begin
                        if (beat) begin
                            r_overrun <= 1'b1;
                        end
                        if (w_isHit) begin
                            r_hit   <= 1'b1;
                            r_score <= w_scoreSat;
                            r_combo <= w_comboInc;
                        end else if (w_isMiss) begin
                            r_miss  <= 1'b1;
                            r_combo <= '0;
                        end
                        r_state  <= S_CLEAR;
                        r_regClr <= 1'b1;
                    end
                    S_CLEAR: begin
                        if (beat) begin
                            r_overrun <= 1'b1;
                        end
                        r_acc    <= 4'd0;
                        r_state  <= S_WAIT_BEAT;
                        r_regClr <= 1'b0;
                    end
                    default: begin
                        r_state  <= S_IDLE;
                        r_regClr <= 1'b1;
                        r_busy   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign reg_clr = r_regClr;
    assign hit     = r_hit;
    assign miss    = r_miss;
    assign score   = r_score;
    assign combo   = r_combo;
    assign overrun = r_overrun;
    assign busy    = r_busy;

endmodule
